// File: rtl/data_memory.sv
// Word-organised data memory with a 1-cycle registered read port.
// It also has a byte-stream program loader that packs little-endian bytes into words.
module data_memory #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              rvalid,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_end,
    output logic              ld_done,
    output logic [1:0]        state
);

    localparam int IDX_W  = ADDR_W - 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    // state encoding on the debug port: IDLE=0, READ=1, LOAD=2
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t            cur_state;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        hold;

    logic [IDX_W-1:0]  req_idx;
    logic              hs;
    logic              ld_consume;
    logic              ld_exit;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [7:0]        hold_nxt;
    logic              mem_we;
    logic [IDX_W-1:0]  widx;
    logic [15:0]       wd;
    logic              unused;

    assign unused     = addr[0];
    assign state      = cur_state;
    assign req_ready  = (cur_state == IDLE) && !ld_start;
    assign req_idx    = addr[ADDR_W-1:1];
    assign hs         = req_valid && req_ready;
    assign ld_consume = (cur_state == LOAD) && ld_valid;
    assign ptr_nxt    = ld_consume ? ptr + 1'b1 : ptr;
    assign hold_nxt   = (ld_consume && !ptr[0]) ? ld_byte : hold;
    assign ld_exit    = (cur_state == LOAD) && (ld_end || (ld_consume && (&ptr)));

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < DEPTH_L;
    endfunction

    // Single write port shared by requester writes, loader word writes and the
    // final flush of a dangling low byte; these never coincide.
    always_comb begin
        mem_we = 1'b0;
        widx   = '0;
        wd     = '0;
        if (hs && we) begin
            mem_we = 1'b1;
            widx   = req_idx;
            wd     = wdata;
        end else if (ld_consume && ptr[0]) begin
            mem_we = 1'b1;
            widx   = ptr[ADDR_W-1:1];
            wd     = {ld_byte, hold};
        end else if (ld_exit && ptr_nxt[0]) begin
            mem_we = 1'b1;
            widx   = ptr_nxt[ADDR_W-1:1];
            wd     = {8'h00, hold_nxt};
        end
        mem_we = mem_we && !rst && in_range(widx);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx[MEM_AW-1:0]] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            rdata     <= 16'h0000;
            rvalid    <= 1'b0;
            ld_done   <= 1'b0;
            ptr       <= '0;
            hold      <= 8'h00;
        end else begin
            rvalid  <= 1'b0;
            ld_done <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (ld_start) begin
                        cur_state <= LOAD;
                        ptr       <= '0;
                        hold      <= 8'h00;
                    end else if (hs && !we) begin
                        rdata     <= in_range(req_idx) ? mem[req_idx[MEM_AW-1:0]] : 16'h0000;
                        rvalid    <= 1'b1;
                        cur_state <= READ;
                    end
                end
                READ: cur_state <= IDLE;
                LOAD: begin
                    ptr  <= ptr_nxt;
                    hold <= hold_nxt;
                    if (ld_exit) begin
                        cur_state <= IDLE;
                        ld_done   <= 1'b1;
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 128, giving the number of 16-bit words stored.
REQ-002 SHALL have parameter ADDR_W, default 8, giving the byte-address width; word index = addr[ADDR_W-1:1].
REQ-003 SHALL have clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have req_valid, input, 1: requester presents an access.
REQ-006 SHALL have req_ready, output, 1: the block accepts the access this cycle.
REQ-007 SHALL have addr, input, ADDR_W: byte address of the access.
REQ-008 SHALL have we, input, 1: 1 = word write, 0 = word read.
REQ-009 SHALL have wdata, input, 16: word to write, already byte-merged by the requester.
REQ-010 SHALL have rdata, output, 16: read word, held until the next accepted read.
REQ-011 SHALL have rvalid, output, 1: one-cycle pulse marking rdata as new.
REQ-012 SHALL have ld_start, input, 1: pulse that enters program-load mode.
REQ-013 SHALL have ld_valid, input, 1: ld_byte carries a program byte.
REQ-014 SHALL have ld_byte, input, 8: program byte.
REQ-015 SHALL have ld_end, input, 1: end of program, sampled with or without ld_valid.
REQ-016 SHALL have ld_done, output, 1: one-cycle pulse when load mode exits.

Function
REQ-017 SHALL have states IDLE, READ and LOAD.
REQ-018 A handshake SHALL occur when req_valid && req_ready are both high on a posedge.
REQ-019 req_ready SHALL be 1 only in IDLE with no ld_start asserted in that cycle.
REQ-020 SHALL ignore addr[0] for storage: reads return the whole word and writes store the whole word.
REQ-021 A write handshake SHALL update mem[addr[ADDR_W-1:1]] at that edge.
  - Stay in IDLE.
  - rvalid stays 0.
REQ-022 A read handshake SHALL capture mem[word index] into rdata at that edge and move to READ.
REQ-023 In READ, rvalid SHALL be 1 for exactly one cycle, then the block returns to IDLE.
  - Read latency: 1 cycle.
  - Throughput: one read per 2 cycles.
  - Writes: one per cycle.
REQ-024 A read issued in the cycle after a write to the same word SHALL return the new data.
REQ-025 A word index >= DEPTH SHALL not be written, and a read of it SHALL return 16'h0000.
REQ-026 ld_start in IDLE SHALL move to LOAD and clear the load pointer (byte address) to 0.
  - ld_start in READ SHALL be ignored.
  - ld_start has priority over a simultaneous req_valid.
REQ-027 In LOAD, each ld_valid cycle SHALL consume one byte, little-endian.
  - Even pointer: byte goes to holding register bits [7:0].
  - Odd pointer: word {ld_byte, hold[7:0]} is written to mem[pointer>>1].
  - Pointer increments by 1 after every consumed byte.
REQ-028 LOAD SHALL exit to IDLE with ld_done = 1 for one cycle on either of these events:
  - ld_end is high.
  - The pointer wraps from 2^ADDR_W-1 to 0 after consuming a byte.
REQ-029 If ld_end coincides with ld_valid, that byte SHALL be consumed first.
REQ-030 On exit with an odd pointer (a pending low byte), the block SHALL write {8'h00, hold[7:0]} to mem[pointer>>1].
REQ-031 In LOAD, req_ready SHALL be 0 and req_valid SHALL have no effect.

Reset
REQ-032 While rst is 1, the block SHALL hold state IDLE, rdata 16'h0000, rvalid 0, ld_done 0, load pointer 0, holding register 0.
REQ-033 The first cycle after rst deasserts, req_ready SHALL be 1.
REQ-034 Reset SHALL NOT clear memory contents.
REQ-035 Reset in LOAD SHALL abandon the load with no write of a pending low byte and no ld_done pulse.
REQ-036 Reset in READ SHALL suppress the pending rvalid.

Verification
REQ-037 Write/read: write addr 8'h10 data 16'hBEEF, then read addr 8'h11 -> next cycle rvalid=1, rdata=16'hBEEF.
REQ-038 Back-to-back: write addr 8'h20 = 16'h1234, read 8'h20 in the next cycle -> rdata=16'h1234; req_ready=0 during the rvalid cycle.
REQ-039 Load: ld_start, bytes 8'h01 8'h02 8'h03, then ld_end -> mem[0]=16'h0201, mem[1]=16'h0003, ld_done pulses once, req_ready returns to 1.
REQ-040 Priority: ld_start with req_valid write in the same cycle -> no write occurs, state LOAD, req_ready=0.
REQ-041 Reset mid-load: ld_start, byte 8'hAA, rst -> mem[0] unchanged, no ld_done, req_ready=1 the cycle after rst falls.
REQ-042 Out of range: read addr 8'hFE with DEPTH=64 -> rdata=16'h0000; write to the same address leaves all words unchanged.
